// File: rtl/voting_pkg.sv
// voting_pkg: shared constants, ballot state encoding and one-hot helper for the voting front end
package voting_pkg;
  localparam int NUM_CAND = 16;
  localparam logic [1:0] resetMode = 2'b00;
  localparam logic [1:0] votingMode = 2'b01;
  localparam logic [1:0] individualCountMode = 2'b10;
  localparam logic [1:0] totalCountMode = 2'b11;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, SEND, GAP, RELEASE} state_t;
  function automatic logic is_one_hot(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/ballot_unit.sv
// ballot_unit: debounces candidate buttons and emits one start/encoder_in vote per deliberate press
module ballot_unit
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int START_CYCLES = 2,
  parameter int GAP_CYCLES = 11,
  parameter int CNT_W = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [NUM_CAND-1:0] btn,
  input  logic                clear_count,
  output logic                start,
  output logic [NUM_CAND-1:0] encoder_in,
  output logic                ready,
  output logic                invalid_press,
  output logic [CNT_W-1:0]    ballots_cast
);
  localparam int MAX_A = DEBOUNCE_CYCLES > START_CYCLES ? DEBOUNCE_CYCLES : START_CYCLES;
  localparam int MAX_C = MAX_A > GAP_CYCLES ? MAX_A : GAP_CYCLES;
  localparam int TW = $clog2(MAX_C + 1);
  state_t state, state_n;
  logic [NUM_CAND-1:0] btn_s, snap, snap_n;
  logic [TW-1:0] tmr, tmr_n;
  logic inv_n;
  sync_2ff #(.W(NUM_CAND)) u_sync (.clk(clk), .reset_n(reset_n), .d(btn), .q(btn_s));
  // One timer is shared: stable-sample count, strobe length, gap length and release count
  always_comb begin
    state_n = state;
    snap_n = snap;
    tmr_n = tmr;
    inv_n = 1'b0;
    case (state)
      IDLE:
        if (enable && btn_s != '0) begin
          state_n = DEBOUNCE;
          snap_n = btn_s;
          tmr_n = TW'(1);
        end
      DEBOUNCE:
        if (!enable || btn_s != snap) state_n = IDLE;
        else if (tmr == TW'(DEBOUNCE_CYCLES)) begin
          state_n = is_one_hot(snap) ? SEND : RELEASE;
          inv_n = !is_one_hot(snap);
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
      SEND:
        if (tmr == TW'(START_CYCLES - 1)) begin
          state_n = GAP;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
      GAP:
        if (tmr == TW'(GAP_CYCLES - 1)) begin
          state_n = RELEASE;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
      RELEASE:
        if (btn_s != '0) tmr_n = '0;
        else if (tmr == TW'(DEBOUNCE_CYCLES - 1)) begin
          state_n = IDLE;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next-state so they line up with the state they describe
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      snap <= '0;
      tmr <= '0;
      start <= 1'b0;
      encoder_in <= '0;
      ready <= 1'b0;
      invalid_press <= 1'b0;
      ballots_cast <= '0;
    end else begin
      state <= state_n;
      snap <= snap_n;
      tmr <= tmr_n;
      start <= state_n == SEND;
      encoder_in <= state_n == SEND ? snap_n : '0;
      ready <= state_n == IDLE && enable;
      invalid_press <= inv_n;
      ballots_cast <= clear_count ? '0 :
                      (state != SEND && state_n == SEND && ballots_cast != '1) ? ballots_cast + 1'b1 :
                      ballots_cast;
    end
endmodule

// File: tb/tb_ballot_unit.sv
// tb_ballot_unit: directed stimulus with a behavioural vote model checked every cycle
module tb_ballot_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [15:0] btn = '0;
  logic clear_count = 1'b0;
  logic start, ready, invalid_press;
  logic [15:0] encoder_in;
  logic [9:0] ballots_cast;
  int checks = 0;
  int errors = 0;

  ballot_unit dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .btn(btn), .clear_count(clear_count),
    .start(start), .encoder_in(encoder_in), .ready(ready), .invalid_press(invalid_press),
    .ballots_cast(ballots_cast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [15:0] v, input int hold, input int rel);
    btn = v;
    tick(hold);
    btn = '0;
    tick(rel);
  endtask

  // Behavioural model: phases of a voter interaction, counted in plain cycles
  localparam int WAITP = 0, CONF = 1, STROBE = 2, REST = 3, AWAITR = 4;
  int ph, seen, left, zeros, m_votes;
  logic [15:0] h0, h1, bs, m_snap;
  logic exp_start, exp_ready, exp_inv;
  logic [15:0] exp_enc;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph = WAITP; seen = 0; left = 0; zeros = 0; m_votes = 0;
      h0 = '0; h1 = '0; m_snap = '0;
      exp_start = 0; exp_ready = 0; exp_inv = 0; exp_enc = '0;
    end else begin
      bs = h1; h1 = h0; h0 = btn;
      exp_inv = 0;
      case (ph)
        WAITP: if (enable && bs != 0) begin ph = CONF; m_snap = bs; seen = 1; end
        CONF:
          if (!enable || bs != m_snap) ph = WAITP;
          else if (seen == 4) begin
            if ($countones(m_snap) == 1) begin
              ph = STROBE; left = 2;
              m_votes = (m_votes + 1 > 1023) ? 1023 : m_votes + 1;
            end else begin
              ph = AWAITR; exp_inv = 1; zeros = 0;
            end
          end else seen++;
        STROBE: begin left--; if (left == 0) begin ph = REST; left = 11; end end
        REST: begin left--; if (left == 0) begin ph = AWAITR; zeros = 0; end end
        default: begin zeros = (bs == 0) ? zeros + 1 : 0; if (zeros == 4) ph = WAITP; end
      endcase
      if (clear_count) m_votes = 0;
      exp_start = ph == STROBE;
      exp_enc = exp_start ? m_snap : '0;
      exp_ready = ph == WAITP && enable;
    end
  end

  int n_rise = 0, n_inv = 0;
  logic prev_start = 0;
  logic [15:0] last_enc = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      chk("start", start, exp_start);
      chk("encoder_in", encoder_in, exp_enc);
      chk("ready", ready, exp_ready);
      chk("invalid_press", invalid_press, exp_inv);
      chk("ballots_cast", ballots_cast, m_votes);
      chk("enc_onehot_or_zero", $countones(encoder_in) <= 1, 1);
    end
    if (start && !prev_start) n_rise++;
    if (invalid_press) n_inv++;
    if (start) last_enc = encoder_in;
    prev_start = start;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, i0, b0, cyc;
    logic sv[1:12];
    logic [15:0] ev[1:12];
    bit found;
    tick(3);
    chk("rst_start", start, 0);
    chk("rst_enc", encoder_in, 0);
    chk("rst_ready", ready, 0);
    chk("rst_ballots", ballots_cast, 0);
    reset_n = 1;
    enable = 1;
    tick(3);
    chk("ready_idle", ready, 1);

    r0 = n_rise; b0 = ballots_cast;
    btn = 16'h0004;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      sv[i] = start;
      ev[i] = encoder_in;
    end
    for (int i = 1; i <= 12; i++) chk($sformatf("clean_start_%0d", i), sv[i], (i == 7 || i == 8));
    chk("clean_enc", ev[7], 16'h0004);
    tick(18);
    btn = '0;
    tick(5);
    chk("clean_ready_before", ready, 0);
    tick(1);
    chk("clean_ready_after", ready, 1);
    chk("clean_votes", ballots_cast, b0 + 1);
    chk("clean_rises", n_rise - r0, 1);

    r0 = n_rise; b0 = ballots_cast;
    for (int k = 0; k < 5; k++) begin
      btn = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      tick(2);
    end
    chk("bounce_no_start", n_rise - r0, 0);
    btn = 16'h0001;
    tick(15);
    btn = '0;
    tick(15);
    chk("bounce_rises", n_rise - r0, 1);
    chk("bounce_enc", last_enc, 16'h0001);
    chk("bounce_votes", ballots_cast, b0 + 1);

    r0 = n_rise; i0 = n_inv; b0 = ballots_cast;
    press(16'h0081, 20, 15);
    chk("multi_inv", n_inv - i0, 1);
    chk("multi_rises", n_rise - r0, 0);
    chk("multi_votes", ballots_cast, b0);

    clear_count = 1;
    tick(1);
    clear_count = 0;
    chk("clear_held", ballots_cast, 0);
    r0 = n_rise;
    btn = 16'h8000;
    tick(200);
    chk("held_one_vote", n_rise - r0, 1);
    btn = '0;
    tick(15);
    press(16'h8000, 30, 15);
    chk("held_rises", n_rise - r0, 2);
    chk("held_votes", ballots_cast, 2);

    r0 = n_rise;
    enable = 0;
    btn = 16'h0010;
    tick(20);
    chk("dis_ready", ready, 0);
    chk("dis_rises", n_rise - r0, 0);
    btn = '0;
    tick(5);
    enable = 1;
    tick(2);
    btn = 16'h0010;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      found = start;
    end
    chk("en_drop_start_seen", found, 1);
    enable = 0;
    cyc = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (start) cyc++;
    end
    chk("en_drop_len", cyc, 2);
    btn = '0;
    tick(20);
    enable = 1;
    tick(3);

    clear_count = 1;
    tick(1);
    clear_count = 0;
    for (int i = 0; i < 1030; i++) press(16'(1 << (i % 16)), 8, 16);
    chk("sat_votes", ballots_cast, 1023);
    clear_count = 1;
    tick(1);
    clear_count = 0;
    chk("clear_votes", ballots_cast, 0);

    btn = 16'h0002;
    tick(6);
    clear_count = 1;
    tick(1);
    clear_count = 0;
    chk("clr_prio_start", start, 1);
    chk("clr_prio_votes", ballots_cast, 0);
    btn = '0;
    tick(20);
    chk("clr_prio_after", ballots_cast, 0);

    btn = 16'h0200;
    tick(7);
    chk("rst_send_start_hi", start, 1);
    chk("rst_send_votes", ballots_cast, 1);
    #2 reset_n = 0;
    #1;
    chk("rst_send_start", start, 0);
    chk("rst_send_enc", encoder_in, 0);
    chk("rst_send_ballots", ballots_cast, 0);
    btn = '0;
    tick(2);
    reset_n = 1;
    tick(2);
    chk("rst_send_idle", ready, 1);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ballot_unit.md
Name: ballot_unit

Overview:
- Voter-side front end that drives the voting machine's ballot input protocol (`start` plus a one-hot 16-bit `encoder_in`).
- Converts raw, bouncy candidate buttons into exactly one well-formed vote transaction per deliberate press:
  - synchronise and debounce the buttons;
  - reject multi-button presses;
  - emit the `start`/`encoder_in` pulse;
  - enforce an inter-vote gap and release-before-revote.
- Sits between the button panel and the voting machine's `start`/`encoder_in` inputs, active only while the machine is in voting mode.

Parameters:
- NUM_CAND, 16, number of candidate buttons (equals the `encoder_in` width)
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a press or a release (≥2)
- START_CYCLES, 2, cycles `start` and `encoder_in` are held per vote
- GAP_CYCLES, 11, idle cycles after `start` drops before release is checked
- CNT_W, 10, width of the `ballots_cast` counter

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  high when the machine is in voting mode (`mode==2'b01`)
- btn  in  NUM_CAND  raw asynchronous candidate buttons, active high
- clear_count  in  1  synchronous clear of `ballots_cast`
- start  out  1  vote strobe to the voting machine
- encoder_in  out  NUM_CAND  one-hot candidate; all-zero when `start` is low
- ready  out  1  unit idle and enabled, accepting a press
- invalid_press  out  1  one-cycle pulse when a multi-button press is rejected
- ballots_cast  out  CNT_W  votes emitted since reset or clear; saturating

Behaviour:
- Reset (async, `reset_n` low): state IDLE; `start`=0, `encoder_in`=0, `ready`=0, `invalid_press`=0, `ballots_cast`=0; synchroniser flops cleared. All outputs are registered.
- `btn` passes through a 2-flop synchroniser; `btn_s` denotes its output. All decisions use `btn_s` only.
- IDLE:
  - `ready`=`enable`.
  - If `enable` && `btn_s`!=0: capture `snap`=`btn_s`, set `stable_cnt`=1, go to DEBOUNCE.
- DEBOUNCE:
  - If `btn_s`!=`snap`: go to IDLE (restarts the press).
  - Else increment `stable_cnt`.
  - On reaching DEBOUNCE_CYCLES with `snap` one-hot: go to SEND.
  - On reaching DEBOUNCE_CYCLES with `snap` not one-hot: pulse `invalid_press` for 1 cycle and go to RELEASE.
  - If `enable` drops: go to IDLE.
- SEND:
  - `start`=1 and `encoder_in`=`snap` for exactly START_CYCLES cycles, then GAP.
  - `ballots_cast` increments once, on entry to SEND; it saturates at 2^CNT_W−1.
  - SEND always completes even if `enable` drops or `btn` changes; a strobe is never truncated.
- GAP: outputs zero for GAP_CYCLES cycles, then RELEASE.
- RELEASE:
  - Wait for `btn_s`==0 on DEBOUNCE_CYCLES consecutive cycles; any nonzero sample restarts the count.
  - Then go to IDLE.
  - A button held down never produces a second vote.
- `ready`=0 in every state except IDLE. `ready`=0 in IDLE while `enable` is low.
- Latency with default parameters: `btn` rises before edge 0 → `btn_s` high at edge 2 → IDLE captures at edge 2 → DEBOUNCE at edges 3–5 → `start` high after edge 6 for 2 cycles.
- `clear_count` has priority over the increment in the same cycle.
- At most one vote is emitted per press/release cycle. `encoder_in` is always 0 or one-hot.
- `reset_n` asserted mid-SEND drops `start` immediately (asynchronously).

Decomposition:
- Package `voting_pkg`:
  - NUM_CAND;
  - mode localparams (`resetMode`=00, `votingMode`=01, `individualCountMode`=10, `totalCountMode`=11);
  - state enum IDLE/DEBOUNCE/SEND/GAP/RELEASE;
  - a one-hot check function.
- Sub-module `sync_2ff`: parameterised-width two-flop synchroniser with async active-low reset, instantiated for `btn`.

Test Plan:
- Clean press: `enable`=1, `btn`=16'h0004 held 30 cycles then released → `start` high exactly 2 cycles, `encoder_in`=16'h0004 on the 6th–7th cycles after `btn` rise; `ballots_cast`=1; `ready` returns to 1 after release + 4 cycles.
- Bounce: `btn`=16'h0001 toggling every 2 cycles for 10 cycles, then stable → exactly one vote, `encoder_in`=16'h0001; no `start` during the bounce.
- Multi-press: `btn`=16'h0081 stable 20 cycles → `invalid_press` single 1-cycle pulse; `start` never asserted; `ballots_cast` unchanged.
- Held button: `btn`=16'h8000 held 200 cycles → exactly one vote; after release and re-press, a second vote; `ballots_cast`=2.
- Enable gating: `enable`=0 with `btn`=16'h0010 → `ready`=0 and no `start`. Drop `enable` mid-SEND → `start` still lasts the full 2 cycles.
- Saturation/clear/reset: 1030 votes → `ballots_cast`=1023. `clear_count` → 0. `reset_n` low during SEND → `start`=0 and `encoder_in`=0 immediately, state IDLE.
